// File: rtl/fp_issue_ctrl.sv
// FP unit issue/writeback scheduler. A slot-reservation shift register arbitrates the
// single result port between misc, pipelined FMA and the iterative divider.
module fp_issue_ctrl #(
  parameter int FMA_LAT = 4,
  parameter int TAG_W   = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_class,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_misc_issue,
  output logic             o_fma_issue,
  output logic             o_div_start,
  input  logic             i_div_done,
  output logic             o_wb_valid,
  output logic [TAG_W-1:0] o_wb_tag,
  output logic [1:0]       o_wb_src,
  output logic             o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [FMA_LAT:0]             r_rsv,  w_rsv_nxt, w_set;
  logic [FMA_LAT:0][TAG_W-1:0]  r_tag,  w_tag_nxt;
  logic [FMA_LAT:0][1:0]        r_src,  w_src_nxt;
  logic [1:0]                   r_dst,  w_dst_nxt;
  logic [TAG_W-1:0]             r_dtag;
  logic                         w_div_hold, w_cls_ok, w_div_wb;
  logic [1:0]                   w_new_src;

  // The div result is stuck behind a pipeline result: new misc/FMA must wait so the
  // port drains. Once the slot frees, the div result leaves and issue may resume.
  assign w_div_hold = r_rsv[0] & ((r_dst == S_PEND) | ((r_dst == S_BUSY) & i_div_done));

  always_comb begin
    w_cls_ok = 1'b0;
    case (i_req_class)
      2'd1:    w_cls_ok = ~w_div_hold;
      2'd2:    w_cls_ok = (r_dst == S_IDLE);
      default: w_cls_ok = ~r_rsv[1] & ~w_div_hold;
    endcase
  end

  assign o_req_ready  = i_rst_n & ~i_clear & w_cls_ok;
  assign o_misc_issue = i_req_valid & o_req_ready & ((i_req_class == 2'd0) | (i_req_class == 2'd3));
  assign o_fma_issue  = i_req_valid & o_req_ready & (i_req_class == 2'd1);
  assign o_div_start  = i_req_valid & o_req_ready & (i_req_class == 2'd2);

  assign w_div_wb = ~i_clear & ~r_rsv[0] &
                    ((r_dst == S_PEND) | ((r_dst == S_BUSY) & i_div_done));

  assign w_new_src = o_fma_issue ? 2'd1 : 2'd0;

  // New reservations are ORed in before the shift, so a misc fire lands in slot 0
  // next cycle and an FMA fire lands in slot FMA_LAT-1.
  always_comb begin
    w_set          = '0;
    w_set[1]       = o_misc_issue;
    w_set[FMA_LAT] = o_fma_issue;
    w_rsv_nxt      = '0;
    w_tag_nxt      = '0;
    w_src_nxt      = '0;
    for (int k = 0; k < FMA_LAT; k++) begin
      w_rsv_nxt[k] = r_rsv[k+1] | w_set[k+1];
      w_tag_nxt[k] = w_set[k+1] ? i_req_tag : r_tag[k+1];
      w_src_nxt[k] = w_set[k+1] ? w_new_src : r_src[k+1];
    end
  end

  always_comb begin
    w_dst_nxt = r_dst;
    case (r_dst)
      S_IDLE:  if (o_div_start) w_dst_nxt = S_BUSY;
      S_BUSY:  if (i_div_done)  w_dst_nxt = r_rsv[0] ? S_PEND : S_IDLE;
      S_PEND:  if (!r_rsv[0])   w_dst_nxt = S_IDLE;
      default: w_dst_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsv  <= '0;
      r_tag  <= '0;
      r_src  <= '0;
      r_dst  <= S_IDLE;
      r_dtag <= '0;
    end else if (i_clear) begin
      r_rsv  <= '0;
      r_tag  <= '0;
      r_src  <= '0;
      r_dst  <= S_IDLE;
      r_dtag <= '0;
    end else begin
      r_rsv <= w_rsv_nxt;
      r_tag <= w_tag_nxt;
      r_src <= w_src_nxt;
      r_dst <= w_dst_nxt;
      if (o_div_start) r_dtag <= i_req_tag;
    end
  end

  // Pipeline results always own the port; the divider only uses free slots.
  always_comb begin
    o_wb_valid = r_rsv[0] | w_div_wb;
    o_wb_tag   = '0;
    o_wb_src   = 2'd0;
    if (r_rsv[0]) begin
      o_wb_tag = r_tag[0];
      o_wb_src = r_src[0];
    end else if (w_div_wb) begin
      o_wb_tag = r_dtag;
      o_wb_src = 2'd2;
    end
  end

  assign o_busy = (|r_rsv) | (r_dst != S_IDLE);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: directed scenarios then random traffic, every cycle checked
// against a model that books result-port usage by absolute cycle number.
module tb_fp_issue_ctrl;
  localparam int FMA_LAT = 4;
  localparam int TAG_W   = 5;

  logic             clk = 1'b0, rst_n = 1'b0, clr = 1'b0, valid = 1'b0, done = 1'b0;
  logic [1:0]       cls = 2'd0;
  logic [TAG_W-1:0] tag = '0;
  logic             ready, misc_iss, fma_iss, div_st, wb_v, busy;
  logic [TAG_W-1:0] wb_tag;
  logic [1:0]       wb_src;

  always #5 clk = ~clk;

  fp_issue_ctrl #(.FMA_LAT(FMA_LAT), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_req_valid(valid), .o_req_ready(ready),
    .i_req_class(cls), .i_req_tag(tag), .o_misc_issue(misc_iss), .o_fma_issue(fma_iss),
    .o_div_start(div_st), .i_div_done(done), .o_wb_valid(wb_v), .o_wb_tag(wb_tag),
    .o_wb_src(wb_src), .o_busy(busy)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  // Model: port bookings per absolute cycle; divider 0=none 1=computing 2=result waiting
  bit               mv[64];
  logic [TAG_W-1:0] mtag[64];
  logic [1:0]       msrc[64];
  int               mdiv = 0;
  logic [TAG_W-1:0] mdtag = '0;
  bit               last_fire = 1'b0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    mdiv = 0;
  endtask

  task automatic step();
    bit own0, own1, waiting, rdy, fire, ewb, ebusy, dwb;
    logic [TAG_W-1:0] etag;
    logic [1:0] esrc;
    #4;
    if (!rst_n) model_flush();
    own0    = mv[cyc % 64];
    own1    = mv[(cyc + 1) % 64];
    waiting = own0 && (mdiv == 2 || (mdiv == 1 && done));
    case (cls)
      2'd1:    rdy = !waiting;
      2'd2:    rdy = (mdiv == 0);
      default: rdy = !own1 && !waiting;
    endcase
    rdy  = rdy && rst_n && !clr;
    fire = valid && rdy;
    dwb  = rst_n && !clr && !own0 && (mdiv == 2 || (mdiv == 1 && done));
    ewb  = own0 || dwb;
    etag = own0 ? mtag[cyc % 64] : mdtag;
    esrc = own0 ? msrc[cyc % 64] : 2'd2;
    ebusy = (mdiv != 0);
    for (int k = 0; k <= FMA_LAT; k++) if (mv[(cyc + k) % 64]) ebusy = 1'b1;

    chk("req_ready", ready, rdy);
    chk("misc_issue", misc_iss, fire && (cls == 2'd0 || cls == 2'd3));
    chk("fma_issue", fma_iss, fire && cls == 2'd1);
    chk("div_start", div_st, fire && cls == 2'd2);
    chk("wb_valid", wb_v, ewb);
    chk("busy", busy, ebusy);
    if (ewb) begin
      chk("wb_tag", wb_tag, etag);
      chk("wb_src", wb_src, esrc);
    end

    mv[cyc % 64] = 1'b0;
    if (clr || !rst_n) model_flush();
    else begin
      if (mdiv == 1 && done) mdiv = own0 ? 2 : 0;
      else if (mdiv == 2 && !own0) mdiv = 0;
      if (fire) begin
        if (cls == 2'd1) begin
          mv[(cyc + FMA_LAT) % 64] = 1'b1; mtag[(cyc + FMA_LAT) % 64] = tag;
          msrc[(cyc + FMA_LAT) % 64] = 2'd1;
        end else if (cls == 2'd2) begin
          mdiv = 1; mdtag = tag;
        end else begin
          mv[(cyc + 1) % 64] = 1'b1; mtag[(cyc + 1) % 64] = tag; msrc[(cyc + 1) % 64] = 2'd0;
        end
      end
    end
    last_fire = fire;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic put(bit v, logic [1:0] c, logic [TAG_W-1:0] t, bit d, bit cl);
    valid = v; cls = c; tag = t; done = d; clr = cl;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) put(1'b0, 2'd0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    model_flush();
    @(posedge clk); #1;
    idle(2);                      // outputs held at 0 under reset
    rst_n = 1'b1;
    idle(2);

    // FMA tag 3: result exactly FMA_LAT cycles later
    put(1, 2'd1, 5'd3, 0, 0); idle(5);

    // FMA tag 1 then misc tag 2 blocked by slot collision, fires one cycle later
    put(1, 2'd1, 5'd1, 0, 0); idle(2);
    put(1, 2'd0, 5'd2, 0, 0); put(1, 2'd0, 5'd2, 0, 0); idle(3);

    // Div tag 7, done with port free: bypass writeback, ready again next cycle
    put(1, 2'd2, 5'd7, 0, 0); idle(19);
    put(0, 2'd2, '0, 1, 0); put(0, 2'd2, '0, 0, 0); idle(2);

    // Div done collides with FMA writeback: div result one cycle later
    put(1, 2'd2, 5'd9, 0, 0); idle(15);
    put(1, 2'd1, 5'd4, 0, 0); idle(3);
    put(0, 2'd0, '0, 1, 0); put(0, 2'd0, '0, 0, 0);
    put(0, 2'd1, '0, 0, 0); idle(2);

    // Back-to-back FMAs return in order
    for (int i = 0; i < 8; i++) put(1, 2'd1, 5'(i), 0, 0);
    idle(5);

    // Div + 2 FMAs flushed by clear; later div_done ignored
    put(1, 2'd2, 5'd5, 0, 0); put(1, 2'd1, 5'd6, 0, 0); put(1, 2'd1, 5'd7, 0, 0);
    idle(2); put(0, 2'd0, '0, 0, 1); idle(2); put(0, 2'd0, '0, 1, 0); idle(5);

    // Same with reset instead of clear
    put(1, 2'd2, 5'd5, 0, 0); put(1, 2'd1, 5'd6, 0, 0); put(1, 2'd1, 5'd7, 0, 0);
    idle(2); rst_n = 1'b0; put(1, 2'd0, 5'd1, 1, 0); idle(1); rst_n = 1'b1;
    idle(2); put(0, 2'd0, '0, 1, 0); idle(5);

    // Random traffic; requester holds class/tag until fire
    for (int i = 0; i < 3000; i++) begin
      if (!(valid && !last_fire)) begin
        valid = ($urandom % 4) != 0;
        cls   = 2'($urandom % 4);
        tag   = TAG_W'($urandom);
      end
      done = ($urandom % 6) == 0;
      clr  = ($urandom % 64) == 0;
      if (i == 1500) rst_n = 1'b0;
      if (i == 1503) rst_n = 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
